// File: rtl/lat_data_mem.sv
// Multi-cycle data memory with valid/ready request/response handshake and byte enables.
// Optional alignment-error response is compiled in with LAT_DATA_MEM_ALIGN_CHECK_EN.

module lat_data_mem_byte (
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  input  logic       be,
  output logic [7:0] merged_b
);
  assign merged_b = be ? new_b : old_b;
endmodule

module lat_data_mem #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 16,
  parameter int LATENCY    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_t;

  typedef struct packed {
    logic                  write;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]     wdata;
    logic [BE_W-1:0]       be;
    logic                  err;
  } req_t;

  state_t             state;
  req_t               req_q;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  mem [1<<DEPTH_LOG2];
  logic [DATA_W-1:0]  old_word;
  logic [DATA_W-1:0]  merged;
  logic               req_err;
  logic               unused_addr;

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign old_word    = mem[req_q.idx];
  assign unused_addr = ^req_addr;

`ifdef LAT_DATA_MEM_ALIGN_CHECK_EN
  assign req_err = |req_addr[OFF-1:0];
`else
  assign req_err = 1'b0;
`endif

  for (genvar g = 0; g < BE_W; g++) begin : g_lane
    lat_data_mem_byte u_byte (
      .old_b   (old_word[8*g +: 8]),
      .new_b   (req_q.wdata[8*g +: 8]),
      .be      (req_q.be[g]),
      .merged_b(merged[8*g +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= '0;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_q.write <= req_write;
          req_q.idx   <= req_addr[DEPTH_LOG2+OFF-1:OFF];
          req_q.wdata <= req_wdata;
          req_q.be    <= req_be;
          req_q.err   <= req_err;
          cnt         <= CNT_W'(LATENCY - 1);
          state       <= (LATENCY > 1) ? WAIT : EXEC;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= EXEC;
        end
        EXEC: begin
          resp_rdata <= req_q.err ? '0 : (req_q.write ? merged : old_word);
          resp_err   <= req_q.err;
          state      <= RESP;
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write only on the closing edge of EXEC; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (!reset && state == EXEC && req_q.write && !req_q.err)
      mem[req_q.idx] <= merged;
  end

endmodule

// File: tb/tb_lat_data_mem.sv
// Bench for lat_data_mem: directed scenarios on two configurations plus randomized traffic
// against an associative-array word model.

module tb_lat_data_mem;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [int];

`ifdef LAT_DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  lat_data_mem #(.DATA_W(32), .DEPTH_LOG2(16), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  lat_data_mem #(.DATA_W(32), .DEPTH_LOG2(4), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  function automatic int exp_lat(input int s);
    return (s == 1) ? 1 : 2;
  endfunction

  function automatic int word_key(input int s, input logic [31:0] a);
    return (s == 1) ? ((1 << 20) | int'(a[5:2])) : int'(a[17:2]);
  endfunction

  task automatic do_reset();
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 0; req_write[s] = 0; req_addr[s] = 0;
      req_wdata[s] = 0; req_be[s] = 0; resp_ready[s] = 0;
    end
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  // One full transaction; lat counts edges from accept to resp_valid.
  task automatic txn(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    int n;
    rd = 0; er = 0; lat = -1;
    @(negedge clk);
    req_valid[s] = 1; req_write[s] = wr; req_addr[s] = addr; req_wdata[s] = wd; req_be[s] = be;
    n = 0;
    while (!req_ready[s] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: req_ready stayed %b, required 1", s, req_ready[s]);
      req_valid[s] = 0;
      return;
    end
    @(posedge clk);
    #1 req_valid[s] = 0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (resp_valid[s] || lat >= 50) break;
      lat++;
    end
    if (!resp_valid[s]) begin
      checks++; errors++;
      $display("FAIL resp_timeout dut%0d: resp_valid stayed %b, required 1", s, resp_valid[s]);
      return;
    end
    rd = resp_rdata[s]; er = resp_err[s];
    resp_ready[s] = 1;
    @(posedge clk);
    #1 resp_ready[s] = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset_req_ready%0d", s), 32'(req_ready[s]), 32'd1);
      chk($sformatf("reset_resp_valid%0d", s), 32'(resp_valid[s]), 32'd0);
      chk($sformatf("reset_resp_rdata%0d", s), resp_rdata[s], 32'd0);
      chk($sformatf("reset_resp_err%0d", s), 32'(resp_err[s]), 32'd0);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_rdata", rd, 32'hDEADBEEF);
    chk("wr_err", 32'(er), 32'd0);
    txn(0, 0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_rdata", rd, 32'hDEADBEEF);
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
    chk("be_merged", rd, 32'hDE22BE44);
    txn(0, 0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    chk("be_readback", rd, 32'hDE22BE44);
    txn(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    chk("be_zero_resp", rd, 32'hDE22BE44);
    txn(0, 0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("be_zero_readback", rd, 32'hDE22BE44);
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    req_valid[0] = 1; req_write[0] = 0; req_addr[0] = 32'h10; req_be[0] = 4'h0;
    @(posedge clk);
    #1 req_valid[0] = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid[0] && n < 50);
    // Second request is presented while the response is stalled.
    req_valid[0] = 1; req_write[0] = 0; req_addr[0] = 32'h10;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_c%0d", i), 32'(resp_valid[0]), 32'd1);
      chk($sformatf("bp_rdata_c%0d", i), resp_rdata[0], 32'hDE22BE44);
      chk($sformatf("bp_ready_c%0d", i), 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    resp_ready[0] = 1;
    @(posedge clk);
    #1 resp_ready[0] = 0;
    @(negedge clk);
    chk("bp_after_hs_ready", 32'(req_ready[0]), 32'd1);
    chk("bp_after_hs_valid", 32'(resp_valid[0]), 32'd0);
    @(posedge clk);
    #1 req_valid[0] = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (resp_valid[0] || n >= 50) break;
      n++;
    end
    chk("bp_second_latency", 32'(n), 32'd2);
    chk("bp_second_rdata", resp_rdata[0], 32'hDE22BE44);
    resp_ready[0] = 1;
    @(posedge clk);
    #1 resp_ready[0] = 0;
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    txn(1, 1, 32'h40, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    chk("wrap_wr_latency", 32'(lat), 32'd1);
    txn(1, 0, 32'h00, 32'h0, 4'h0, rd, er, lat);
    chk("wrap_rd_latency", 32'(lat), 32'd1);
    chk("wrap_rdata", rd, 32'hA5A5A5A5);
  endtask

  task automatic abort_write(input int edges_before_reset);
    @(negedge clk);
    req_valid[0] = 1; req_write[0] = 1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'hFFFFFFFF; req_be[0] = 4'hF;
    @(posedge clk);
    #1 req_valid[0] = 0;
    repeat (edges_before_reset) @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk($sformatf("abort%0d_resp_valid", edges_before_reset), 32'(resp_valid[0]), 32'd0);
    chk($sformatf("abort%0d_req_ready", edges_before_reset), 32'(req_ready[0]), 32'd1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1, 32'h20, 32'h12345678, 4'hF, rd, er, lat);
    abort_write(0);
    abort_write(1);
    txn(0, 0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("abort_readback", rd, 32'h12345678);
    @(negedge clk);
    req_valid[0] = 1; req_write[0] = 0; req_addr[0] = 32'h20;
    @(posedge clk);
    #1 req_valid[0] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("resp_pending_valid", 32'(resp_valid[0]), 32'd1);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("resp_discard_valid", 32'(resp_valid[0]), 32'd0);
    chk("resp_discard_ready", 32'(req_ready[0]), 32'd1);
  endtask

  task automatic test_align();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1, 32'h22, 32'h0, 4'hF, rd, er, lat);
    chk("align_err", 32'(er), ALIGN ? 32'd1 : 32'd0);
    chk("align_rdata", rd, 32'h0);
    txn(0, 0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("align_readback", rd, ALIGN ? 32'h12345678 : 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, addr, hi, exp_rd, cur; logic er, exp_er; int lat, s, k; bit wr;
    logic [3:0] be;
    for (int t = 0; t < 2; t++)
      for (int w = 0; w < 16; w++) begin
        wd = $urandom;
        txn(t, 1, 32'(w << 2), wd, 4'hF, rd, er, lat);
        mdl[word_key(t, 32'(w << 2))] = wd;
      end
    for (int i = 0; i < 150; i++) begin
      s  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      hi = $urandom;
      hi = (s == 1) ? (hi & 32'hFFFF_FFC0) : (hi & 32'hFFFC_0000);
      addr = hi | 32'($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
      wd = $urandom; be = 4'($urandom);
      k = word_key(s, addr);
      cur = mdl[k];
      exp_er = ALIGN && (addr[1:0] != 2'b00);
      if (exp_er) exp_rd = 32'h0;
      else if (wr) begin
        exp_rd = cur;
        for (int b = 0; b < 4; b++) if (be[b]) exp_rd[8*b +: 8] = wd[8*b +: 8];
        mdl[k] = exp_rd;
      end else exp_rd = cur;
      txn(s, wr, addr, wd, be, rd, er, lat);
      checks++;
      if (rd !== exp_rd || er !== exp_er || lat != exp_lat(s)) begin
        errors++;
        $display("FAIL rand%0d dut%0d wr=%0b addr=%h: rdata/err/lat %h/%b/%0d, required %h/%b/%0d",
                 i, s, wr, addr, rd, er, lat, exp_rd, exp_er, exp_lat(s));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_align();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/lat_data_mem.md
Name: lat_data_mem

Overview:
- Parametrised data memory with a multi-cycle, handshaked access path, for the multicycle and pipelined cores.
- Generalises word width, depth and access latency.
- Adds per-byte write enables and a valid/ready request/response protocol.
- Adds an optional alignment-error response.
- One transaction is in flight at a time. The core stalls on req_ready and resp_valid.

Parameters:
- DATA_W, 32, word width in bits; must be 32 or 64.
- DEPTH_LOG2, 16, log2 of the number of words.
- LATENCY, 2, cycles from request accept to response valid; must be >= 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_W  read data, or merged written word for writes.
- resp_err  out  1  alignment error (see Optional Feature).

Behaviour:
- Addressing:
  - OFF = log2(DATA_W/8).
  - Word index = req_addr[DEPTH_LOG2+OFF-1:OFF].
  - Address bits above the index are ignored, so addresses wrap modulo the memory size.
- Reset:
  - State is IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Memory array contents are not cleared.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch write, word index, wdata, be and err flag. Load the counter with LATENCY-1.
  - Next state is WAIT if LATENCY>1, else EXEC.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge; at 1, the next state is EXEC.
- EXEC (one cycle, req_ready=0). On its closing edge:
  - If err: resp_rdata<=0 and memory is untouched.
  - Else if read: resp_rdata<=mem[idx].
  - Else (write): each byte i with be[i]=1 is replaced by wdata byte i; bytes with be=0 keep the old value. The memory is written and resp_rdata<=merged word.
  - resp_err<=err. Next state is RESP.
- RESP:
  - resp_valid=1, req_ready=0.
  - resp_rdata and resp_err are held stable until the edge with resp_ready=1.
  - That edge moves the state to IDLE.
- Latency: a request accepted at edge E0 has resp_valid high in the cycle after edge E0+LATENCY. With no backpressure, the next request can be accepted one cycle later.
- Back-to-back requests: req_ready is combinational from state (high only in IDLE). A req_valid outside IDLE is not accepted and must be held by the requester.
- Write with be=0: no bytes change, a response is still returned, and resp_rdata = the unchanged word.
- Reset mid-operation (in WAIT or EXEC cycle): the transaction is aborted and the memory write is not performed. In RESP, the pending response is discarded.
- Simultaneous reset and handshake: reset wins.

Optional Feature:
- Macro: LAT_DATA_MEM_ALIGN_CHECK_EN.
- Defined:
  - A request with req_addr[OFF-1:0] != 0 is accepted normally with err=1.
  - It completes with resp_err=1 and resp_rdata=0.
  - A write performs no memory update.
- Undefined:
  - The low OFF address bits are ignored, so misaligned addresses access the containing word.
  - resp_err is tied to 0.

Test Plan (DATA_W=32, LATENCY=2 unless noted):
- Reset, then write addr 0x10, wdata 0xDEADBEEF, be=4'hF; hold resp_ready=1 -> resp_valid 2 cycles after accept. Then read 0x10 -> resp_rdata=0xDEADBEEF.
- Write 0x10 with wdata 0x11223344, be=4'b0101 -> following read returns 0xDE22BE44.
- Read 0x10 with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable all 5 cycles. req_ready stays 0 and a second req_valid is not accepted until after the resp handshake edge.
- DEPTH_LOG2=4: write 0x40 with 0xA5A5A5A5 -> a read of 0x00 returns 0xA5A5A5A5 (wrap-around). With LATENCY=1, resp_valid appears 1 cycle after accept.
- Write 0x20 with 0x12345678, then assert reset during WAIT of a write of 0x20 with 0xFFFFFFFF -> after reset, resp_valid=0 and req_ready=1; a read of 0x20 returns 0x12345678.
- With LAT_DATA_MEM_ALIGN_CHECK_EN: write 0x22 with 0x0 -> resp_err=1, resp_rdata=0; a read of 0x20 is unchanged. Without the macro, the same write updates the word at 0x20 and resp_err=0.
